// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MIPS core constants and decoder control bundle
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
                                    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                    alu_op: ALUOP_ADD};

  // rt is a destination only for I-type writers (addi, lw).
  function automatic logic rt_is_source(input ctrl_t c);
    return !(!c.reg_dst && c.alu_src && !c.mem_write);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detect against the EX load
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_rt_is_src,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_valid,
  output logic              o_stall
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_rs);
  assign w_rt_match = (i_ex_rt == i_rt) && i_rt_is_src;
  assign o_stall    = i_ex_mem_read && i_ex_valid && (i_ex_rt != '0) &&
                      (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall; ID_EX_PERF_CNT_EN adds bubble_cnt_o
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [5:0]        funct_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_RegDst_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_MemtoReg_o,
  output logic              ex_RegWrite_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic [1:0]        ex_ALUOp_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [5:0]        ex_funct_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              ex_valid_o
);

  ctrl_t             w_id_ctrl;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [5:0]        r_funct;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              w_stall;
  logic              w_load_bubble;

  assign w_id_ctrl = '{reg_dst: RegDst_i, alu_src: ALUSrc_i, mem_to_reg: MemtoReg_i,
                       reg_write: RegWrite_i, mem_read: MemRead_i, mem_write: MemWrite_i,
                       alu_op: ALUOp_i};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .i_rs          (rs_i),
    .i_rt          (rt_i),
    .i_rt_is_src   (rt_is_source(w_id_ctrl)),
    .i_ex_rt       (r_rt),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_valid    (r_valid),
    .o_stall       (w_stall)
  );

  assign w_load_bubble = flush_i || w_stall;

  // Bubbles still capture data and specifiers; only control and valid are cleared.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_valid   <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_funct   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (!hold_i) begin
      r_ctrl    <= w_load_bubble ? CTRL_BUBBLE : w_id_ctrl;
      r_valid   <= !w_load_bubble;
      r_rs_data <= rs_data_i;
      r_rt_data <= rt_data_i;
      r_imm     <= imm_i;
      r_funct   <= funct_i;
      r_rs      <= rs_i;
      r_rt      <= rt_i;
      r_rd      <= rd_i;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (!hold_i && w_load_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  assign stall_o       = w_stall;
  assign ex_RegDst_o   = r_ctrl.reg_dst;
  assign ex_ALUSrc_o   = r_ctrl.alu_src;
  assign ex_MemtoReg_o = r_ctrl.mem_to_reg;
  assign ex_RegWrite_o = r_ctrl.reg_write;
  assign ex_MemRead_o  = r_ctrl.mem_read;
  assign ex_MemWrite_o = r_ctrl.mem_write;
  assign ex_ALUOp_o    = r_ctrl.alu_op;
  assign ex_rs_data_o  = r_rs_data;
  assign ex_rt_data_o  = r_rt_data;
  assign ex_imm_o      = r_imm;
  assign ex_funct_o    = r_funct;
  assign ex_rs_o       = r_rs;
  assign ex_rt_o       = r_rt;
  assign ex_rd_o       = r_rd;
  assign ex_valid_o    = r_valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS core, directly downstream of the main decoder (`Control`). It captures the decoder's control bits, the register-file operands, the sign-extended immediate and the register specifiers on every clock. It also detects load-use hazards against the instruction currently in EX. On a hazard it stalls PC and IF/ID and injects a single bubble into EX, and it squashes ID on a flush request.

## Interface
- `DATA_W`, default 32: operand/immediate width.
- `REG_AW`, default 5: register specifier width.
- `clk_i` in, 1: clock; all state on rising edge.
- `rst_i` in, 1: reset, asynchronous, active-low.
- `RegDst_i`, `ALUSrc_i`, `MemtoReg_i`, `RegWrite_i`, `MemRead_i`, `MemWrite_i` in, 1 each: decoder control bits for the ID instruction.
- `ALUOp_i` in, 2: decoder ALU op class.
- `rs_data_i`, `rt_data_i` in, DATA_W: register-file read data.
- `imm_i` in, DATA_W: sign-extended immediate.
- `funct_i` in, 6: instruction[5:0].
- `rs_i`, `rt_i`, `rd_i` in, REG_AW: specifiers of the ID instruction.
- `hold_i` in, 1: global freeze; holds all state.
- `flush_i` in, 1: squash the ID instruction (taken branch/jump resolved in ID).
- `stall_o` out, 1: load-use stall request to PC and IF/ID write enables; combinational.
- `ex_*_o` out: registered copies of every `*_i` above, prefixed `ex_`, with the same widths.
- `ex_valid_o` out, 1: EX holds a real instruction, not a bubble.

## Operation
- Register update priority per edge:
  - `hold_i` holds everything.
  - Else `flush_i` or `stall_o` loads a bubble.
  - Else the stage loads the ID inputs and sets `ex_valid_o`=1.
- Bubble contents:
  - all control outputs 0 and `ALUOp`=00;
  - `ex_valid_o`=0;
  - data and specifier fields are still loaded, so downstream logic must gate them on the control bits.
- rt is treated as a source unless the ID instruction is an I-type destination: `RegDst_i`=0, `ALUSrc_i`=1 and `MemWrite_i`=0 (addi, lw).
- Load-use detect, combinational. `stall_o` = `ex_MemRead_o` & `ex_valid_o` & (`ex_rt_o` != 0) & (rs match | rt match), where:
  - rs match = (`ex_rt_o` == `rs_i`);
  - rt match = (`ex_rt_o` == `rt_i`) & rt-is-source.
- Because a bubble clears `ex_MemRead_o`, `stall_o` lasts exactly one cycle per hazard. The waiting instruction re-enters on the following edge.
- `flush_i` together with a hazard: a bubble is loaded. `stall_o` still asserts; IF/ID owns the flush/stall priority.
- `stall_o` is not gated by `hold_i`.

## Timing
- Latency from ID inputs to `ex_*_o`: 1 cycle.
- `stall_o` is valid in the same cycle as the ID inputs, with no registered delay.
- Reset is asynchronous and active-low. While `rst_i`=0, all outputs are 0, including `ex_valid_o` and `stall_o`.
- Release from reset is synchronous to the next rising edge.
- Reset mid-stall clears state; no hazard survives reset.
- Specifier comparisons are REG_AW bits wide. Register $0 never hazards.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - adds output `bubble_cnt_o`, 32 bits;
  - it increments on every edge that loads a bubble and `hold_i`=0;
  - it wraps at 2^32-1 to 0 and resets to 0.
- Not defined: the port and counter are absent, with no other behavioural change.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010);
  - the `ALUOp` encodings 00/10/11;
  - a packed control-bundle typedef.
- One sub-module, `load_use_detect`: purely combinational; takes the ID specifiers, rt-is-source, `ex_rt_o`, `ex_MemRead_o` and `ex_valid_o`, and drives `stall_o`.
- The pipeline register stays in the top.

## Test plan
- Reset: hold `rst_i`=0 while inputs toggle → all `ex_*_o`=0, `ex_valid_o`=0, `stall_o`=0. Release → the next edge loads inputs.
- R-type pass-through: `RegDst`=1, `RegWrite`=1, `ALUOp`=10, `rs_data`=0x12, `rt_data`=0x34, rd=8 → the same values appear on `ex_*_o` one cycle later with `ex_valid_o`=1.
- Load-use:
  - Setup: lw $2 in EX; add $3,$2,$4 in ID.
  - Same cycle: `stall_o`=1.
  - Next cycle: bubble (`ex_RegWrite_o`=0, `ex_valid_o`=0) and `stall_o`=0.
  - Cycle after: the add loads.
- No false hazard:
  - lw $2 in EX then addi $2,$5,1 in ID (rt is destination) → `stall_o`=0.
  - lw $0 in EX with rs=0 → `stall_o`=0.
- Flush and hold:
  - `flush_i`=1 with sw in ID → the next EX has `MemWrite`=0 and `ex_valid_o`=0.
  - `hold_i`=1 for 3 cycles with changing inputs → outputs unchanged.
- With `ID_EX_PERF_CNT_EN`: 1 load-use bubble plus 2 flushes → `bubble_cnt_o`=3. Bubbles under `hold_i` are not counted.
